bicubic_scheduler: RTL
======================

Name: bicubic_scheduler

Overview:
Sequencer for the bicubic resize datapath. It walks every target pixel of a TW x TH output, maps it to a source position inside the SW x SH window at (H0,V0), and issues the 16 image-ROM reads for the 4x4 neighbourhood. It hands the fractional weights to the interpolation datapath, waits for its result, writes it to ResultSRAM, and raises DONE after the last pixel.

Parameters:
IMG_W, 100, source image width in pixels (ROM row pitch)
IMG_H, 100, source image height
ROM_AW, 14, ROM address width
SRAM_AW, 12, result SRAM address width

Ports:
CLK  in  1  clock; all logic on posedge
RST  in  1  synchronous active-low reset
START  in  1  one-cycle launch pulse; ignored while BUSY
H0  in  7  source window left column
V0  in  7  source window top row
SW  in  5  source window width (>=1)
SH  in  5  source window height (>=1)
TW  in  6  target width (>=1)
TH  in  6  target height (>=1)
ROM_RD  out  1  ROM read strobe
ROM_A  out  ROM_AW  ROM address = row*IMG_W + col
TAP_VLD  out  1  ROM_Q (1-cycle ROM latency) holds tap TAP_IDX this cycle
TAP_IDX  out  4  tap index, row-major: dy*4+dx, offsets -1..+2
FX_NUM  out  6  horizontal fraction numerator
FY_NUM  out  6  vertical fraction numerator
FX_DEN  out  6  TW-1 (0 when TW==1)
FY_DEN  out  6  TH-1 (0 when TH==1)
DP_GO  out  1  pulse: 16 taps delivered, start interpolation
DP_VLD  in  1  datapath result valid (pixel on datapath bus)
SRAM_WEN  out  1  result write strobe
SRAM_A  out  SRAM_AW  ty*TW + tx
BUSY  out  1  job in progress
DONE  out  1  one-cycle pulse after final write

Behaviour:
- Reset (RST==0 at posedge): FSM->IDLE. All outputs 0 next cycle. Counters and latched params cleared. Applies in any state; an aborted job produces no further writes and no DONE.
- FSM: IDLE -> SETUP -> FETCH -> DRAIN -> WAIT -> WRITE -> STEP -> (FETCH | FIN) -> IDLE.
- IDLE: BUSY=0. START=1 -> SETUP.
- SETUP (1 cycle): latch H0,V0,SW,SH,TW,TH. Clear tx,ty,ix,iy,rx,ry. BUSY=1 from here through FIN.
- FETCH (16 cycles, k=0..15): ROM_RD=1.
  - col = clamp(H0+ix+(k%4)-1, H0, H0+SW-1); row = clamp(V0+iy+(k/4)-1, V0, V0+SH-1).
  - TAP_VLD/TAP_IDX lag ROM_RD/k by exactly 1 cycle.
- DRAIN (1 cycle): last TAP_VLD (idx 15); DP_GO=1 the same cycle.
- FX_NUM=rx and FY_NUM=ry are stable from FETCH entry until WRITE completes.
- WAIT: hold until DP_VLD=1; no ROM_RD or SRAM_WEN while waiting; unbounded stall allowed.
- DP_VLD is sampled only in WAIT; pulses in other states are ignored.
- WRITE (1 cycle): SRAM_WEN=1, SRAM_A=ty*TW+tx.
- STEP, horizontal DDA: src_x = tx*(SW-1)/(TW-1) = ix + rx/(TW-1).
  - If tx<TW-1: tx++, rx+=SW-1. Then while rx>=TW-1: rx-=TW-1, ix++, one subtraction per cycle, staying in STEP.
  - If tx==TW-1: tx=0, ix=0, rx=0, ty++, and the same DDA runs on ry/iy with SH-1, TH-1.
  - TW==1 (TH==1): step forced 0, so ix (iy) stays 0 and rx (ry) stays 0.
- STEP exit: when the DDA is settled -> FETCH, unless the pixel just written was (TW-1,TH-1) -> FIN.
- FIN (1 cycle): DONE=1, BUSY=0 next cycle -> IDLE.
- START in FIN or IDLE is accepted only in IDLE; the next job starts with fresh params, so DONE always pulses low->high->low.
- Arithmetic: rx,ry 7-bit internally (max 61+30); ROM_A computed with 14-bit unsigned multiply-by-constant; no wrap.
- Per-pixel latency = 16+1+dp_latency+1+1+subtract_cycles.

Test Plan:
- Identity H0=V0=0, SW=SH=TW=TH=4, DP_VLD 2 cycles after DP_GO -> 16 writes SRAM_A 0..15; FX_NUM=FY_NUM=0; ix==tx; exactly one DONE pulse.
- Upscale H0=V0=0, SW=5, TW=9, SH=TH=1 -> FX_DEN=8; tx=1: ix=0,FX_NUM=4; tx=2: ix=1,FX_NUM=0; tx=8: ix=4,FX_NUM=0; SRAM_A 0..8.
- Clamp H0=10, V0=20, SW=SH=4, pixel (0,0) -> tap0 ROM_A=2010; tap5 ROM_A=2010; tap15 ROM_A=2212; TAP_IDX lags ROM_RD by 1.
- Downscale SW=9, TW=3, SH=TH=1 -> tx=1 STEP lasts 4 subtract cycles, ix=4, FX_NUM=0; tx=2: ix=8; DONE after 3 writes.
- Stall: DP_VLD held low 20 cycles in WAIT -> ROM_RD, SRAM_WEN stay 0, FSM stays in WAIT, then exactly one write; stray DP_VLD during FETCH produces no write.
- RST low during FETCH of pixel 3, then START with new params -> outputs 0 the cycle after reset; no DONE for the aborted job; new job writes from SRAM_A=0; START while BUSY has no effect.

Source files
------------

// File: rtl/bicubic_scheduler.sv
// Bicubic resize sequencer: walks every target pixel, fetches the clamped
// 4x4 source neighbourhood from the image ROM, hands the fractional weights
// to the interpolation datapath and writes each result to the result SRAM.
module bicubic_scheduler #(
  parameter int IMG_W   = 100,
  parameter int IMG_H   = 100,
  parameter int ROM_AW  = 14,
  parameter int SRAM_AW = 12
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [6:0]         H0,
  input  logic [6:0]         V0,
  input  logic [4:0]         SW,
  input  logic [4:0]         SH,
  input  logic [5:0]         TW,
  input  logic [5:0]         TH,
  output logic               ROM_RD,
  output logic [ROM_AW-1:0]  ROM_A,
  output logic               TAP_VLD,
  output logic [3:0]         TAP_IDX,
  output logic [5:0]         FX_NUM,
  output logic [5:0]         FY_NUM,
  output logic [5:0]         FX_DEN,
  output logic [5:0]         FY_DEN,
  output logic               DP_GO,
  input  logic               DP_VLD,
  output logic               SRAM_WEN,
  output logic [SRAM_AW-1:0] SRAM_A,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_DRAIN, S_WAIT, S_WRITE, S_STEP, S_FIN
  } state_t;

  // Upper limits keep the ROM address inside the image even if a window overhangs it.
  localparam logic [8:0] COL_MAX = 9'(IMG_W - 1);
  localparam logic [8:0] ROW_MAX = 9'(IMG_H - 1);

  state_t      state_q, state_d;
  logic [6:0]  h0_q, h0_d, v0_q, v0_d;
  logic [4:0]  sw_q, sw_d, sh_q, sh_d;
  logic [5:0]  tw_q, tw_d, th_q, th_d;
  logic [5:0]  tx_q, tx_d, ty_q, ty_d;
  logic [5:0]  ix_q, ix_d, iy_q, iy_d;
  logic [6:0]  rx_q, rx_d, ry_q, ry_d;
  logic [3:0]  k_q, k_d;
  logic        sub_q, sub_d;
  logic        tap_vld_q, tap_vld_d;
  logic [3:0]  tap_idx_q, tap_idx_d;

  logic [5:0]  den_x, den_y;
  logic [6:0]  step_x, step_y;
  logic [8:0]  col, row;
  logic [ROM_AW-1:0] rom_addr;

  // True while the fraction accumulator still holds a whole source step.
  function automatic logic needs_sub(input logic [6:0] r, input logic [5:0] den);
    return (den != 6'd0) && (r >= {1'b0, den});
  endfunction

  // Tap coordinate (base+idx+off-1) clamped to the window [base, base+size-1].
  function automatic logic [8:0] clamp_tap(input logic [6:0] base, input logic [5:0] idx,
                                           input logic [1:0] off, input logic [4:0] size,
                                           input logic [8:0] lim);
    logic [8:0] pos_p1, lo, hi, r;
    pos_p1 = {2'b00, base} + {3'b000, idx} + {7'd0, off};
    lo     = {2'b00, base};
    hi     = (size == 5'd0) ? lo : lo + {4'd0, size} - 9'd1;
    if (pos_p1 <= lo)              r = lo;
    else if (pos_p1 - 9'd1 > hi)   r = hi;
    else                           r = pos_p1 - 9'd1;
    if (r > lim) r = lim;
    return r;
  endfunction

  // Fraction denominators and per-pixel source steps; a single-pixel axis never advances.
  always_comb begin
    den_x    = (tw_q == 6'd0) ? 6'd0 : tw_q - 6'd1;
    den_y    = (th_q == 6'd0) ? 6'd0 : th_q - 6'd1;
    step_x   = (den_x == 6'd0 || sw_q == 5'd0) ? 7'd0 : {2'b00, sw_q - 5'd1};
    step_y   = (den_y == 6'd0 || sh_q == 5'd0) ? 7'd0 : {2'b00, sh_q - 5'd1};
    col      = clamp_tap(h0_q, ix_q, k_q[1:0], sw_q, COL_MAX);
    row      = clamp_tap(v0_q, iy_q, k_q[3:2], sh_q, ROW_MAX);
    rom_addr = ROM_AW'(row) * ROM_AW'(IMG_W) + ROM_AW'(col);
  end

  // Next-state, counter and DDA update.
  always_comb begin
    state_d   = state_q;
    h0_d      = h0_q;
    v0_d      = v0_q;
    sw_d      = sw_q;
    sh_d      = sh_q;
    tw_d      = tw_q;
    th_d      = th_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    ix_d      = ix_q;
    iy_d      = iy_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    k_d       = k_q;
    sub_d     = sub_q;
    tap_vld_d = (state_q == S_FETCH);
    tap_idx_d = k_q;
    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_SETUP;
      end
      S_SETUP: begin
        h0_d    = H0;
        v0_d    = V0;
        sw_d    = SW;
        sh_d    = SH;
        tw_d    = TW;
        th_d    = TH;
        tx_d    = 6'd0;
        ty_d    = 6'd0;
        ix_d    = 6'd0;
        iy_d    = 6'd0;
        rx_d    = 7'd0;
        ry_d    = 7'd0;
        k_d     = 4'd0;
        sub_d   = 1'b0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WAIT;
      S_WAIT: begin
        if (DP_VLD) state_d = S_WRITE;
      end
      S_WRITE: begin
        sub_d   = 1'b0;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (!sub_q) begin
          // First STEP cycle advances the target pixel and accumulates the fraction.
          if (tx_q == den_x && ty_q == den_y) begin
            state_d = S_FIN;
          end else begin
            if (tx_q != den_x) begin
              tx_d = tx_q + 6'd1;
              rx_d = rx_q + step_x;
            end else begin
              tx_d = 6'd0;
              ix_d = 6'd0;
              rx_d = 7'd0;
              ty_d = ty_q + 6'd1;
              ry_d = ry_q + step_y;
            end
            sub_d = 1'b1;
          end
        end else if (needs_sub(rx_q, den_x)) begin
          rx_d = rx_q - {1'b0, den_x};
          ix_d = ix_q + 6'd1;
        end else if (needs_sub(ry_q, den_y)) begin
          ry_d = ry_q - {1'b0, den_y};
          iy_d = iy_q + 6'd1;
        end
        // Leave as soon as the updated accumulators are below one whole step.
        if (state_d == S_STEP && !needs_sub(rx_d, den_x) && !needs_sub(ry_d, den_y)) begin
          state_d = S_FETCH;
          k_d     = 4'd0;
          sub_d   = 1'b0;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched job parameters and counters; reset aborts any job in flight.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      h0_q      <= '0;
      v0_q      <= '0;
      sw_q      <= '0;
      sh_q      <= '0;
      tw_q      <= '0;
      th_q      <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      ix_q      <= '0;
      iy_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      k_q       <= '0;
      sub_q     <= 1'b0;
      tap_vld_q <= 1'b0;
      tap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      h0_q      <= h0_d;
      v0_q      <= v0_d;
      sw_q      <= sw_d;
      sh_q      <= sh_d;
      tw_q      <= tw_d;
      th_q      <= th_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      ix_q      <= ix_d;
      iy_q      <= iy_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      k_q       <= k_d;
      sub_q     <= sub_d;
      tap_vld_q <= tap_vld_d;
      tap_idx_q <= tap_idx_d;
    end
  end

  assign ROM_RD   = (state_q == S_FETCH);
  assign ROM_A    = (state_q == S_FETCH) ? rom_addr : '0;
  assign TAP_VLD  = tap_vld_q;
  assign TAP_IDX  = tap_idx_q;
  assign FX_NUM   = rx_q[5:0];
  assign FY_NUM   = ry_q[5:0];
  assign FX_DEN   = den_x;
  assign FY_DEN   = den_y;
  assign DP_GO    = (state_q == S_DRAIN);
  assign SRAM_WEN = (state_q == S_WRITE);
  assign SRAM_A   = (state_q == S_WRITE) ?
                    SRAM_AW'(ty_q) * SRAM_AW'(tw_q) + SRAM_AW'(tx_q) : '0;
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FIN);

endmodule
